// File: rtl/eth_pkg.sv
// eth_pkg: FSM states, framing constants and the byte-wide CRC-32 step shared by eth_frame_tx.
package eth_pkg;
   typedef enum logic [2:0] {
      ST_IDLE, ST_PREAMBLE, ST_SFD, ST_PAYLOAD, ST_PAD, ST_FCS, ST_IFG, ST_DRAIN
   } eth_state_e;
   localparam logic [10:0] MIN_FRAME_LEN = 11'd60;
   localparam logic [3:0]  IFG_BYTES     = 4'd12;
   localparam logic [7:0]  ETH_PREAMBLE  = 8'h55;
   localparam logic [7:0]  ETH_SFD       = 8'hD5;
   localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
   localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
   localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

   function automatic logic [31:0] reflect32(input logic [31:0] v);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) r[i] = v[31-i];
      return r;
   endfunction

   // LSB-first (reflected) CRC update for one byte, no final inversion
   function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
      logic [31:0] c;
      c = crc ^ {24'h0, d};
      for (int i = 0; i < 8; i++) c = c[0] ? (c >> 1) ^ reflect32(CRC32_POLY) : c >> 1;
      return c;
   endfunction
endpackage

// File: rtl/eth_crc32.sv
// eth_crc32: registered CRC-32 accumulator, one byte per enabled cycle, synchronous clear to the init value.
module eth_crc32
   import eth_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        clr_i,
   input  logic        en_i,
   input  logic [7:0]  data_i,
   output logic [31:0] crc_o
);
   logic [31:0] crc_q, crc_d;

   assign crc_d = clr_i ? CRC32_INIT : en_i ? crc32_byte(crc_q, data_i) : crc_q;
   assign crc_o = crc_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) crc_q <= CRC32_INIT;
      else          crc_q <= crc_d;
   end
endmodule

// File: rtl/eth_frame_tx.sv
// eth_frame_tx: AXI-Stream to GMII Ethernet frame transmitter with preamble/SFD and inter-frame gap.
// Define ETH_TX_FCS_EN to add minimum-length padding and CRC-32 FCS insertion.
module eth_frame_tx
   import eth_pkg::*;
(
   input  logic       clk_125mhz,
   input  logic       rst_n,
   input  logic [7:0] s_axis_tdata,
   input  logic       s_axis_tvalid,
   output logic       s_axis_tready,
   input  logic       s_axis_tlast,
   input  logic       s_axis_tuser,
   output logic [7:0] gmii_txd,
   output logic       gmii_tx_en,
   output logic       gmii_tx_er,
   output logic       tx_busy,
   output logic       frame_done,
   output logic       underflow
);
   eth_state_e  state_q;
   logic [10:0] cnt_q, cnt_inc;
   logic [3:0]  aux_q;

   assign cnt_inc       = (cnt_q == 11'h7FF) ? cnt_q : cnt_q + 11'd1;
   assign s_axis_tready = (state_q == ST_PAYLOAD) || (state_q == ST_DRAIN);
   assign tx_busy       = (state_q != ST_IDLE);

`ifdef ETH_TX_FCS_EN
   logic        bad_q;
   logic [31:0] crc;
   logic [7:0]  fcs_byte;

   assign fcs_byte = ~crc[{aux_q[1:0], 3'b000} +: 8];

   eth_crc32 u_crc (
      .clk_i   (clk_125mhz),
      .rst_n_i (rst_n),
      .clr_i   (state_q == ST_IDLE),
      .en_i    ((state_q == ST_PAYLOAD && s_axis_tvalid) || state_q == ST_PAD),
      .data_i  (state_q == ST_PAD ? 8'h00 : s_axis_tdata),
      .crc_o   (crc)
   );
`endif

   always_ff @(posedge clk_125mhz or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         aux_q      <= '0;
         gmii_txd   <= '0;
         gmii_tx_en <= 1'b0;
         gmii_tx_er <= 1'b0;
         frame_done <= 1'b0;
         underflow  <= 1'b0;
`ifdef ETH_TX_FCS_EN
         bad_q      <= 1'b0;
`endif
      end else begin
         gmii_txd   <= 8'h00;
         gmii_tx_en <= 1'b0;
         gmii_tx_er <= 1'b0;
         frame_done <= 1'b0;
         underflow  <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               cnt_q <= '0;
               aux_q <= '0;
               if (s_axis_tvalid) state_q <= ST_PREAMBLE;
            end
            ST_PREAMBLE: begin
               gmii_txd   <= ETH_PREAMBLE;
               gmii_tx_en <= 1'b1;
               aux_q      <= (aux_q == 4'd6) ? 4'd0 : aux_q + 4'd1;
               if (aux_q == 4'd6) state_q <= ST_SFD;
            end
            ST_SFD: begin
               gmii_txd   <= ETH_SFD;
               gmii_tx_en <= 1'b1;
               state_q    <= ST_PAYLOAD;
            end
            ST_PAYLOAD: begin
               gmii_tx_en <= 1'b1;
               if (!s_axis_tvalid) begin
                  gmii_tx_er <= 1'b1;
                  underflow  <= 1'b1;
                  state_q    <= ST_DRAIN;
               end else begin
                  gmii_txd <= s_axis_tdata;
                  cnt_q    <= cnt_inc;
                  if (s_axis_tlast) begin
`ifdef ETH_TX_FCS_EN
                     bad_q   <= s_axis_tuser;
                     state_q <= (cnt_inc < MIN_FRAME_LEN) ? ST_PAD : ST_FCS;
`else
                     gmii_tx_er <= s_axis_tuser;
                     frame_done <= 1'b1;
                     state_q    <= ST_IFG;
`endif
                  end
               end
            end
`ifdef ETH_TX_FCS_EN
            ST_PAD: begin
               gmii_tx_en <= 1'b1;
               cnt_q      <= cnt_inc;
               if (cnt_inc == MIN_FRAME_LEN) state_q <= ST_FCS;
            end
            ST_FCS: begin
               gmii_txd   <= fcs_byte;
               gmii_tx_en <= 1'b1;
               gmii_tx_er <= bad_q && (aux_q == 4'd0);
               frame_done <= (aux_q == 4'd3);
               aux_q      <= (aux_q == 4'd3) ? 4'd0 : aux_q + 4'd1;
               if (aux_q == 4'd3) state_q <= ST_IFG;
            end
`endif
            ST_IFG: begin
               // the IDLE cycle that follows completes the IFG_BYTES-long gap
               aux_q <= (aux_q == IFG_BYTES - 4'd2) ? 4'd0 : aux_q + 4'd1;
               if (aux_q == IFG_BYTES - 4'd2) state_q <= ST_IDLE;
            end
            ST_DRAIN: if (s_axis_tvalid && s_axis_tlast) state_q <= ST_IFG;
            default: state_q <= ST_IDLE;
         endcase
      end
   end
endmodule
